// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display.
package display_pkg;

  // Scan phases: GUARD blanks every digit, ON lights the current digit.
  typedef enum logic {
    GUARD = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  // Active-low segment pattern with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Largest digit count the scanner is built for.
  localparam int MAX_DIGITS = 8;

endpackage

// File: rtl/BCD_to_sevenSeg.sv
// Hex nibble to active-low {a..g} segment decoder (0-9, A, b, C, d, E, F).
module BCD_to_sevenSeg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup; the caller registers the result.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner: per-digit GUARD/ON timing, a shadow
// register that only reloads at frame boundaries, and leading-zero blanking.
module seven_seg_scanner
  import display_pkg::scan_state_t;
  import display_pkg::SEG_BLANK;
#(
  parameter int N_DIGITS = 8,
  parameter int DWELL    = 100000,
  parameter int GUARD    = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  lz_en,
  input  logic                  load_req,
  input  logic [4*N_DIGITS-1:0] data_in,
  output logic                  load_ack,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [6:0]            segments,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(N_DIGITS);

  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] GUARD_LD = CW'(GUARD - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  wrap_q, wrap_d;       // last digit done, boundary pending
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic                  idle_ack_q, idle_ack_d;
  logic [N_DIGITS-1:0]   anodes_q, anodes_d;
  logic [6:0]            segments_q, segments_d;
  logic                  frame_done_q, frame_done_d;

  logic [3:0]            nib [N_DIGITS];
  logic [N_DIGITS-1:0]   lit_mask;
  logic                  seen_nz;
  logic [6:0]            dec_seg;

  // Outputs are computed from next-state values so they line up with the state.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
    assign nib[gi] = shadow_d[4*gi +: 4];
  end

  BCD_to_sevenSeg u_dec (
    .bcd (nib[idx_d]),
    .seg (dec_seg)
  );

  // State register and all output/shadow flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= display_pkg::GUARD;
      cnt_q        <= GUARD_LD;
      idx_q        <= '0;
      wrap_q       <= 1'b0;
      shadow_q     <= '0;
      idle_ack_q   <= 1'b0;
      anodes_q     <= '1;
      segments_q   <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wrap_q       <= wrap_d;
      shadow_q     <= shadow_d;
      idle_ack_q   <= idle_ack_d;
      anodes_q     <= anodes_d;
      segments_q   <= segments_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: dwell/guard down-counter; disabling parks at GUARD of digit 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap_d  = wrap_q;
    if (!en) begin
      state_d = display_pkg::GUARD;
      cnt_d   = GUARD_LD;
      idx_d   = '0;
      wrap_d  = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else if (state_q == display_pkg::GUARD) begin
      state_d = display_pkg::ON;
      cnt_d   = DWELL_LD;
      wrap_d  = 1'b0;
    end else begin
      state_d = display_pkg::GUARD;
      cnt_d   = GUARD_LD;
      idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
      wrap_d  = (idx_q == LAST_IDX);
    end
  end

  // Load handshake: capture at a frame boundary, or one cycle after a request while idle.
  assign load_ack = (frame_done_q & load_req) | idle_ack_q;

  // Shadow capture and the idle-mode acknowledge.
  always_comb begin
    shadow_d = shadow_q;
    if (load_ack) begin
      shadow_d = data_in;
    end
    idle_ack_d = ~en & load_req & ~load_ack;
  end

  // Leading-zero mask: a digit stays lit once any nibble at or above it is nonzero.
  always_comb begin
    lit_mask = '0;
    seen_nz  = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      seen_nz     = seen_nz | (nib[k] != 4'd0);
      lit_mask[k] = seen_nz | ~lz_en | (k == 0);
    end
  end

  // Output decode for the upcoming cycle: one anode low in ON, dark otherwise.
  always_comb begin
    frame_done_d = (state_d == display_pkg::GUARD) && (cnt_d == '0) && wrap_d;
    anodes_d     = '1;
    segments_d   = SEG_BLANK;
    if (state_d == display_pkg::ON && lit_mask[idx_d]) begin
      anodes_d[idx_d] = 1'b0;
      segments_d      = dec_seg;
    end
  end

  assign anodes     = anodes_q;
  assign segments   = segments_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with N_DIGITS=4, DWELL=4, GUARD=2.
module tb_seven_seg_scanner;

  localparam int ND    = 4;
  localparam int FRAME = 24;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        lz_en;
  logic        load_req;
  logic [15:0] data_in;
  logic        load_ack;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          lz;
    logic [15:0]   data;
    logic [3:0]    blank;   // digits expected dark
    logic [3:0][6:0] seg;   // {d3,d2,d1,d0} expected patterns
  } vec_t;

  vec_t vecs [9];

  seven_seg_scanner #(
    .N_DIGITS (ND),
    .DWELL    (4),
    .GUARD    (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .lz_en      (lz_en),
    .load_req   (load_req),
    .data_in    (data_in),
    .load_ack   (load_ack),
    .anodes     (anodes),
    .segments   (segments),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int t, logic [3:0] ea, logic [6:0] es, logic efd, logic eack);
    total++;
    if ({anodes, segments, frame_done, load_ack} !== {ea, es, efd, eack}) begin
      bad++;
      $display("FAIL %s t=%0d got an=%b seg=%b fd=%b ack=%b want an=%b seg=%b fd=%b ack=%b",
               nm, t, anodes, segments, frame_done, load_ack, ea, es, efd, eack);
    end
  endtask

  task automatic chk_bit(string nm, logic got, logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  // Cycle t counts from the first cycle after scanning is (re)enabled.
  function automatic void exp_disp(int vi, int t, output logic [3:0] an, output logic [6:0] sg);
    int f = t % FRAME;
    int d = f / 6;
    an = 4'hF;
    sg = 7'h7F;
    if ((f % 6) >= 2 && !vecs[vi].blank[d]) begin
      an = ~(4'b0001 << d);
      sg = vecs[vi].seg[d];
    end
  endfunction

  function automatic logic fd_at(int t);
    return (t >= FRAME) && (t % FRAME == 1);
  endfunction

  task automatic chk_frame(string nm, int vi, int t, logic efd, logic eack);
    logic [3:0] ea;
    logic [6:0] es;
    exp_disp(vi, t, ea, es);
    chk(nm, t, ea, es, efd, eack);
  endtask

  // Load while disabled: acknowledge arrives exactly one cycle after the request.
  task automatic load_idle(logic [15:0] d);
    load_req = 1'b1;
    data_in  = d;
    @(negedge clk);
    chk_bit("idle_ack_early", load_ack, 1'b0);
    tick();
    @(negedge clk);
    chk_bit("idle_ack", load_ack, 1'b1);
    tick();
    load_req = 1'b0;
    @(negedge clk);
    chk_bit("idle_ack_clr", load_ack, 1'b0);
  endtask

  task automatic prep(int vi, logic lz);
    tick();
    en = 1'b0;
    tick();
    load_idle(vecs[vi].data);
    tick();
    lz_en = lz;
    en    = 1'b1;
  endtask

  task automatic run_vec(int vi);
    prep(vi, vecs[vi].lz);
    for (int t = 0; t < 2*FRAME + 2; t++) begin
      @(negedge clk);
      chk_frame("vec", vi, t, fd_at(t), 1'b0);
    end
    $display("vec %0d data=%h lz=%b checked", vi, vecs[vi].data, vecs[vi].lz);
  endtask

  task automatic seq_midload(int rise_t);
    prep(0, 1'b0);
    for (int t = 0; t <= 2*FRAME + 2; t++) begin
      if (t > 0) tick();
      if (t == rise_t) begin
        load_req = 1'b1;
        data_in  = vecs[8].data;
      end
      if (t == FRAME + 2) load_req = 1'b0;
      @(negedge clk);
      chk_frame("midload", (t < FRAME + 2) ? 0 : 8, t, fd_at(t), t == FRAME + 1);
    end
    $display("midload request at t=%0d checked", rise_t);
  endtask

  initial begin
    reset_n  = 1'b0;
    en       = 1'b0;
    lz_en    = 1'b0;
    load_req = 1'b0;
    data_in  = 16'h0000;

    vecs[0] = '{lz:1'b0, data:16'h1234, blank:4'b0000,
                seg:{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
    vecs[1] = '{lz:1'b1, data:16'h0070, blank:4'b1100,
                seg:{7'b0000001, 7'b0000001, 7'b0001111, 7'b0000001}};
    vecs[2] = '{lz:1'b1, data:16'h0000, blank:4'b1110,
                seg:{7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};
    vecs[3] = '{lz:1'b0, data:16'hABCF, blank:4'b0000,
                seg:{7'b0001000, 7'b1100000, 7'b0110001, 7'b0111000}};
    vecs[4] = '{lz:1'b1, data:16'h0105, blank:4'b1000,
                seg:{7'b0000001, 7'b1001111, 7'b0000001, 7'b0100100}};
    vecs[5] = '{lz:1'b0, data:16'h0000, blank:4'b0000,
                seg:{7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};
    vecs[6] = '{lz:1'b1, data:16'h8D96, blank:4'b0000,
                seg:{7'b0000000, 7'b1000010, 7'b0000100, 7'b0100000}};
    vecs[7] = '{lz:1'b1, data:16'hE000, blank:4'b0000,
                seg:{7'b0110000, 7'b0000001, 7'b0000001, 7'b0000001}};
    vecs[8] = '{lz:1'b0, data:16'h5678, blank:4'b0000,
                seg:{7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", 0, 4'hF, 7'h7F, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;

    // Table-driven frames
    for (int vi = 0; vi < 8; vi++) begin
      run_vec(vi);
    end

    // Mid-frame request, and a request first raised on the boundary cycle
    seq_midload(5);
    seq_midload(FRAME + 1);

    // Enable dropped mid-ON, idle load, then restart from GUARD of digit 0
    prep(0, 1'b0);
    for (int t = 0; t < 46; t++) begin
      if (t > 0) tick();
      if (t == 10) en = 1'b0;
      if (t == 12) begin
        load_req = 1'b1;
        data_in  = vecs[6].data;
      end
      if (t == 14) load_req = 1'b0;
      if (t == 16) en = 1'b1;
      @(negedge clk);
      if (t <= 10)     chk_frame("en_run", 0, t, 1'b0, 1'b0);
      else if (t < 16) chk("en_off", t, 4'hF, 7'h7F, 1'b0, t == 13);
      else             chk_frame("en_restart", 6, t - 16, fd_at(t - 16), 1'b0);
    end
    $display("enable drop sequence checked");

    // Reset mid-frame with a request pending across it
    prep(0, 1'b0);
    for (int t = 0; t < 61; t++) begin
      if (t > 0) tick();
      if (t == 8) begin
        reset_n  = 1'b0;
        load_req = 1'b1;
        data_in  = vecs[3].data;
        #2;
        chk("reset_async", t, 4'hF, 7'h7F, 1'b0, 1'b0);
      end else if (t == 9) begin
        @(negedge clk);
        chk("reset_hold", t, 4'hF, 7'h7F, 1'b0, 1'b0);
      end else begin
        if (t == 10) reset_n = 1'b1;
        if (t == 10 + FRAME + 2) load_req = 1'b0;
        @(negedge clk);
        if (t < 8) chk_frame("pre_reset", 0, t, 1'b0, 1'b0);
        else chk_frame("post_reset", (t - 10 < FRAME + 2) ? 5 : 3, t - 10,
                       fd_at(t - 10), (t - 10) == FRAME + 1);
      end
    end
    $display("reset mid-frame sequence checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
